decode_seq: RTL and testbench
=============================

DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 The block SHALL take one parameter: DWELL, default 100, the number of clock cycles each 3-bit code is held (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the sweep and return to IDLE.
REQ-006 The block SHALL have port hold, input, 1 bit: while high in RUN, freeze the code and the dwell counter.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 up, 01 down, 10 gray, 11 single up sweep; latched on start.
REQ-008 The block SHALL have ports a, b, c, output, 1 bit each: code to the 3-to-8 decoder, {a,b,c} with a as MSB.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-010 The block SHALL have port step, output, 1 bit: one-cycle pulse when a new code is presented.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of each full 8-code sweep.
REQ-012 The block SHALL have port sweeps, output, 8 bits: count of completed sweeps since the last start.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 The FSM SHALL have two states, IDLE and RUN. Internal state: idx[2:0], dwell_cnt (16 bits), and the latched mode.
REQ-015 The code SHALL be mapped from idx and the latched mode as follows: up and single give idx; down gives 7-idx; gray gives idx XOR (idx>>1).
REQ-016 In IDLE, {a,b,c} SHALL be 000, busy 0, step 0, done 0, and sweeps SHALL hold its value.
REQ-017 IDLE to RUN: when start=1 and stop=0 at edge N, then after edge N: busy=1, idx=0, {a,b,c}=code(0), step=1, dwell_cnt=0, sweeps=0, mode latched.
REQ-018 Each code SHALL be held for exactly DWELL non-hold cycles. When dwell_cnt reaches DWELL-1 and hold=0, the next edge SHALL set idx=idx+1 (mod 8), present the new code, pulse step, and clear dwell_cnt.
REQ-019 When idx=7 completes its dwell, the same edge SHALL pulse done and increment sweeps, saturating at 255.
- Modes 00, 01 and 10: idx wraps to 0 and RUN continues, with step=1.
- Mode 11: go to IDLE, {a,b,c}=000, busy=0, step=0.
REQ-020 While hold=1 in RUN, idx, dwell_cnt and the code SHALL freeze, and step and done SHALL stay 0; counting resumes on the first cycle with hold=0.
REQ-021 stop=1 in RUN SHALL take priority over hold and over dwell expiry. The next edge SHALL give IDLE, {a,b,c}=000, busy=0, and no done pulse; sweeps SHALL hold its value.
REQ-022 start in RUN SHALL be ignored; mode changes in RUN SHALL be ignored until the next start.
REQ-023 start=1 and stop=1 together in IDLE SHALL keep the block in IDLE.
REQ-024 With DWELL=1, the code SHALL change every cycle and step SHALL stay high continuously in continuous modes.
REQ-025 A full sweep SHALL take exactly 8*DWELL non-hold cycles from the start edge to the done edge.

Reset
REQ-026 When rst=1, the block SHALL immediately, without waiting for a clock edge, force IDLE, {a,b,c}=000, busy=0, step=0, done=0, sweeps=0, idx=0, dwell_cnt=0, and latched mode=00.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after rst falls SHALL behave as in REQ-017.

Verification (bench uses DWELL=2)
REQ-028 Mode 00, start pulsed 1 cycle -> {a,b,c} goes 000,001,...,111, each held 2 cycles; step is high on each change; done is high at cycle 16 with sweeps=1; the code returns to 000 and busy stays 1.
REQ-029 Mode 11 -> one sweep 000..111, then done=1, busy=0, {a,b,c}=000, sweeps=1; a second start clears sweeps to 0.
REQ-030 Mode 10 -> sequence 000,001,011,010,110,111,101,100; mode 01 -> sequence 111 down to 000.
REQ-031 hold=1 for 5 cycles while code 011 is presented -> code 011 lasts 7 cycles and done is delayed by 5 cycles.
REQ-032 stop at code 101 -> next cycle {a,b,c}=000 and busy=0 with no done; start+stop together in IDLE -> busy stays 0.
REQ-033 rst pulsed asynchronously between clock edges at code 110 -> outputs go to 000 and sweeps=0 before the next edge; no done.

Source files
------------

// File: rtl/decode_seq_if.sv
// Handshake and code-output bundle for decode_seq.
// The slave modport is the sequencer side; the master modport is the driver side.
interface decode_seq_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] mode;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       step;
    logic       done;
    logic [7:0] sweeps;

    modport slave (
        input  start, stop, hold, mode,
        output a, b, c, busy, step, done, sweeps
    );

    modport master (
        output start, stop, hold, mode,
        input  a, b, c, busy, step, done, sweeps
    );
endinterface

// File: rtl/decode_seq.sv
// Sweeps a 3-bit code for a 3-to-8 decoder through up/down/gray/single-shot orders,
// holding each code for DWELL cycles. Every output comes straight from a register.
module decode_seq #(
    parameter int unsigned DWELL = 100
) (
    input  logic          clk,
    input  logic          rst,
    decode_seq_if.slave   bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0]  LP_MODE_UP     = 2'b00;
    localparam logic [1:0]  LP_MODE_DOWN   = 2'b01;
    localparam logic [1:0]  LP_MODE_GRAY   = 2'b10;
    localparam logic [1:0]  LP_MODE_SINGLE = 2'b11;
    localparam logic [15:0] LP_LAST        = 16'(DWELL - 1);

    state_t      r_state,  w_state_nxt;
    logic [2:0]  r_idx,    w_idx_nxt;
    logic [15:0] r_dwell,  w_dwell_nxt;
    logic [1:0]  r_mode,   w_mode_nxt;
    logic [2:0]  r_code,   w_code_nxt;
    logic        r_busy,   w_busy_nxt;
    logic        r_step,   w_step_nxt;
    logic        r_done,   w_done_nxt;
    logic [7:0]  r_sweeps, w_sweeps_nxt;

    function automatic logic [2:0] f_code(input logic [2:0] idx, input logic [1:0] mode);
        case (mode)
            LP_MODE_DOWN: f_code = 3'd7 - idx;
            LP_MODE_GRAY: f_code = idx ^ (idx >> 1);
            default:      f_code = idx;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_dwell_nxt  = r_dwell;
        w_mode_nxt   = r_mode;
        w_code_nxt   = r_code;
        w_busy_nxt   = r_busy;
        w_step_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_sweeps_nxt = r_sweeps;

        case (r_state)
            IDLE: begin
                w_code_nxt = 3'b000;
                w_busy_nxt = 1'b0;
                if (bus.start && !bus.stop) begin
                    w_state_nxt  = RUN;
                    w_idx_nxt    = 3'd0;
                    w_dwell_nxt  = 16'd0;
                    w_mode_nxt   = bus.mode;
                    w_code_nxt   = f_code(3'd0, bus.mode);
                    w_busy_nxt   = 1'b1;
                    w_step_nxt   = 1'b1;
                    w_sweeps_nxt = 8'd0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 3'd0;
                    w_dwell_nxt = 16'd0;
                    w_code_nxt  = 3'b000;
                    w_busy_nxt  = 1'b0;
                end else if (!bus.hold) begin
                    if (r_dwell == LP_LAST) begin
                        w_dwell_nxt = 16'd0;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_code_nxt  = f_code(r_idx + 3'd1, r_mode);
                        w_step_nxt  = 1'b1;
                        if (r_idx == 3'd7) begin
                            w_done_nxt   = 1'b1;
                            w_sweeps_nxt = (r_sweeps == 8'hFF) ? r_sweeps : r_sweeps + 8'd1;
                            // Single-shot sweeps end here instead of wrapping.
                            if (r_mode == LP_MODE_SINGLE) begin
                                w_state_nxt = IDLE;
                                w_code_nxt  = 3'b000;
                                w_busy_nxt  = 1'b0;
                                w_step_nxt  = 1'b0;
                            end
                        end
                    end else begin
                        w_dwell_nxt = r_dwell + 16'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= 3'd0;
            r_dwell  <= 16'd0;
            r_mode   <= LP_MODE_UP;
            r_code   <= 3'b000;
            r_busy   <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
            r_sweeps <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_dwell  <= w_dwell_nxt;
            r_mode   <= w_mode_nxt;
            r_code   <= w_code_nxt;
            r_busy   <= w_busy_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
            r_sweeps <= w_sweeps_nxt;
        end
    end

    assign bus.a      = r_code[2];
    assign bus.b      = r_code[1];
    assign bus.c      = r_code[0];
    assign bus.busy   = r_busy;
    assign bus.step   = r_step;
    assign bus.done   = r_done;
    assign bus.sweeps = r_sweeps;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq with DWELL=2: directed scenarios then random traffic,
// all checked against a model that tracks elapsed non-hold cycles since start.
module tb_decode_seq;

    localparam int DWELL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decode_seq_if bus ();

    decode_seq #(.DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: running flag, latched mode, non-hold cycles since start, sweep count.
    bit       m_run;
    bit [1:0] m_mode;
    int       m_t;
    int       m_sweeps;
    bit       m_step;
    bit       m_done;
    int       gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    function automatic void model_reset();
        m_run = 0; m_mode = 0; m_t = 0; m_sweeps = 0; m_step = 0; m_done = 0;
    endfunction

    function automatic void model_edge(input bit st, input bit sp, input bit hd, input bit [1:0] md);
        m_step = 0;
        m_done = 0;
        if (!m_run) begin
            if (st && !sp) begin
                m_run = 1; m_mode = md; m_t = 0; m_sweeps = 0; m_step = 1;
            end
        end else if (sp) begin
            m_run = 0;
        end else if (!hd) begin
            m_t++;
            if (m_t % DWELL == 0) m_step = 1;
            if (m_t == 8 * DWELL) begin
                m_done = 1;
                m_t = 0;
                if (m_sweeps < 255) m_sweeps++;
                if (m_mode == 2'b11) begin
                    m_run = 0;
                    m_step = 0;
                end
            end
        end
    endfunction

    function automatic int model_code();
        int k;
        if (!m_run) return 0;
        k = m_t / DWELL;
        case (m_mode)
            2'b01:   return 7 - k;
            2'b10:   return gray_tab[k];
            default: return k;
        endcase
    endfunction

    task automatic check_outs(input string tag);
        logic [2:0] exp_code = 3'(model_code());
        logic [2:0] obs_code = {bus.a, bus.b, bus.c};
        n_vec++;
        assert (obs_code === exp_code) else begin
            n_err++; $error("FAIL %s code: observed %b expected %b", tag, obs_code, exp_code);
        end
        n_vec++;
        assert (bus.busy === m_run) else begin
            n_err++; $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, m_run);
        end
        n_vec++;
        assert (bus.step === m_step) else begin
            n_err++; $error("FAIL %s step: observed %b expected %b", tag, bus.step, m_step);
        end
        n_vec++;
        assert (bus.done === m_done) else begin
            n_err++; $error("FAIL %s done: observed %b expected %b", tag, bus.done, m_done);
        end
        n_vec++;
        assert (bus.sweeps === 8'(m_sweeps)) else begin
            n_err++; $error("FAIL %s sweeps: observed %0d expected %0d", tag, bus.sweeps, m_sweeps);
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input bit hd, input bit [1:0] md, input string tag);
        bus.start = st;
        bus.stop  = sp;
        bus.hold  = hd;
        bus.mode  = md;
        @(posedge clk);
        model_edge(st, sp, hd, md);
        #1;
        check_outs(tag);
    endtask

    task automatic idle_cycles(input int n, input bit [1:0] md, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, md, tag);
    endtask

    // Pulses rst between edges and checks the outputs cleared before the next edge.
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1 model_reset();
        check_outs(tag);
        #2 rst = 1'b0;
    endtask

    initial begin
        int done_at;
        int n;

        bus.start = 0; bus.stop = 0; bus.hold = 0; bus.mode = 2'b00;
        model_reset();
        #2 check_outs("reset");
        #10 rst = 1'b0;
        idle_cycles(2, 2'b00, "idle");

        // Up mode, continuous: done at cycle 16, wraps and stays busy.
        cycle(1, 0, 0, 2'b00, "up_start");
        idle_cycles(20, 2'b01, "up_run");
        cycle(0, 1, 0, 2'b00, "up_stop");

        // Single sweep ends in IDLE; restart clears sweeps.
        cycle(1, 0, 0, 2'b11, "single_start");
        idle_cycles(17, 2'b00, "single_run");
        cycle(1, 0, 0, 2'b11, "single_restart");
        cycle(0, 1, 0, 2'b00, "single_stop");

        // Gray and down sweeps, with ignored start/mode changes mid-run.
        cycle(1, 0, 0, 2'b10, "gray_start");
        cycle(1, 0, 0, 2'b00, "gray_start_ignored");
        idle_cycles(17, 2'b01, "gray_run");
        cycle(0, 1, 0, 2'b00, "gray_stop");
        cycle(1, 0, 0, 2'b01, "down_start");
        idle_cycles(17, 2'b10, "down_run");
        cycle(0, 1, 0, 2'b00, "down_stop");

        // Hold 5 cycles on code 011: done lands 5 cycles late.
        cycle(1, 0, 0, 2'b00, "hold_start");
        n = 0;
        for (int i = 0; i < 20 && !(m_run && m_t / DWELL == 3); i++) begin
            cycle(0, 0, 0, 2'b00, "hold_pre");
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 2'b00, "hold_on");
            n++;
        end
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 2'b00, "hold_post");
            n++;
            if (bus.done) begin
                done_at = n;
                break;
            end
        end
        n_vec++;
        assert (done_at === 8 * DWELL + 5) else begin
            n_err++; $error("FAIL hold_done_cycle: observed %0d expected %0d", done_at, 8 * DWELL + 5);
        end
        cycle(0, 1, 0, 2'b00, "hold_stop");

        // Stop at code 101, and start+stop together in IDLE.
        cycle(1, 0, 0, 2'b00, "stop_start");
        for (int i = 0; i < 20 && !(m_run && m_t / DWELL == 5); i++) cycle(0, 0, 0, 2'b00, "stop_pre");
        cycle(0, 1, 1, 2'b00, "stop_at_101");
        cycle(1, 1, 0, 2'b00, "start_stop_idle");
        idle_cycles(2, 2'b00, "idle_after");

        // Asynchronous reset at code 110.
        cycle(1, 0, 0, 2'b00, "rst_start");
        for (int i = 0; i < 20 && !(m_run && m_t / DWELL == 6); i++) cycle(0, 0, 0, 2'b00, "rst_pre");
        async_reset("async_rst");
        idle_cycles(2, 2'b00, "rst_post");
        cycle(1, 0, 0, 2'b10, "rst_restart");
        cycle(0, 1, 0, 2'b00, "rst_restart_stop");

        // Long up run to reach sweep-count saturation.
        cycle(1, 0, 0, 2'b00, "sat_start");
        idle_cycles(260 * 8 * DWELL, 2'b00, "sat_run");
        cycle(0, 1, 0, 2'b00, "sat_stop");
        idle_cycles(2, 2'b00, "sat_idle");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end else begin
                cycle($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
